// File: rtl/rca_seq_ctrl_if.sv
// Operand/result bundle for rca_seq_ctrl.
// The master drives the request side; the slave returns status and result.
interface rca_seq_ctrl_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         op;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

  modport master (
    output start, a, b, cin, op,
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin, op,
    output busy, done, sum, cout
  );
endinterface

// File: rtl/rca_seq_ctrl.sv
// Sequential adder that reuses one 4-bit ripple-carry slice across NIBBLES passes.
// Optional subtraction is enabled by defining RCA_SEQ_CTRL_SUB_EN.
module rca_seq_ctrl #(
  parameter int NIBBLES = 4
) (
  input logic          clk,
  input logic          rst,
  rca_seq_ctrl_if.slave bus
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;
  logic [W-1:0]     work_q, work_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             sub_q, sub_d;

  logic             start_sub;
  logic             start_carry;
  logic [3:0]       slice_a;
  logic [3:0]       slice_b;
  logic [3:0]       slice_s;
  logic [4:0]       slice_c;

`ifdef RCA_SEQ_CTRL_SUB_EN
  // Subtraction is a + ~b + 1, so the incoming carry is forced high and cin is ignored.
  assign start_sub   = bus.op;
  assign start_carry = bus.op ? 1'b1 : bus.cin;
`else
  logic unused_op;
  assign unused_op   = bus.op;
  assign start_sub   = 1'b0;
  assign start_carry = bus.cin;
`endif

  assign slice_a    = a_q[{idx_q, 2'b00} +: 4];
  assign slice_b    = b_q[{idx_q, 2'b00} +: 4] ^ {4{sub_q}};
  assign slice_c[0] = carry_q;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign slice_s[i]   = slice_a[i] ^ slice_b[i] ^ slice_c[i];
    assign slice_c[i+1] = (slice_a[i] & slice_b[i]) | (slice_c[i] & (slice_a[i] ^ slice_b[i]));
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    sub_d   = sub_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sub_d   = start_sub;
          carry_d = start_carry;
          idx_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        work_d[{idx_q, 2'b00} +: 4] = slice_s;
        carry_d = slice_c[4];
        if (idx_q == LAST_IDX) begin
          // Result registers only change here, so they hold the old result during RUN.
          sum_d   = work_d;
          cout_d  = slice_c[4];
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      sub_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      sub_q   <= sub_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = (state_q == S_DONE);
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_rca_seq_ctrl.sv
// Directed self-checking bench for rca_seq_ctrl (NIBBLES = 4).
// Expected subtraction results follow RCA_SEQ_CTRL_SUB_EN as compiled.
module tb_rca_seq_ctrl;
  localparam int NIBBLES = 4;

  logic clk = 1'b0;
  logic rst;
  int   tests_run    = 0;
  int   tests_failed = 0;

  rca_seq_ctrl_if #(.NIBBLES(NIBBLES)) bus ();

  rca_seq_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present operands at a falling edge, hold start across one rising edge (T0).
  task automatic accept_op(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic op);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = cin;
    bus.op    = op;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int cycles, output bit seen);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 20) begin
      @(negedge clk);
      cycles++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
    bus.op    = 1'b0;
    #3;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done); end
    tests_run++; if (bus.sum !== 16'h0000) begin tests_failed++; $display("[TB] FAIL reset_sum: got %h expected 0000", bus.sum); end
    tests_run++; if (bus.cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_cout: got %b expected 0", bus.cout); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_latency();
    accept_op(16'h0000, 16'h0000, 1'b0, 1'b0);
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL lat_busy_t0: got %b expected 1", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_done_t0: got %b expected 0", bus.done); end
    for (int k = 1; k <= NIBBLES + 1; k++) begin
      @(negedge clk);
      tests_run++; if (bus.done !== (k == NIBBLES)) begin tests_failed++; $display("[TB] FAIL lat_done_t%0d: got %b expected %b", k, bus.done, (k == NIBBLES)); end
      tests_run++; if (bus.busy !== (k <= NIBBLES)) begin tests_failed++; $display("[TB] FAIL lat_busy_t%0d: got %b expected %b", k, bus.busy, (k <= NIBBLES)); end
      if (k == NIBBLES) begin
        tests_run++; if (bus.sum !== 16'h0000) begin tests_failed++; $display("[TB] FAIL lat_sum: got %h expected 0000", bus.sum); end
        tests_run++; if (bus.cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL lat_cout: got %b expected 0", bus.cout); end
      end
    end
  endtask

  task automatic test_ignore_start();
    accept_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.a     = 16'hFFFF;
    bus.b     = 16'hFFFF;
    bus.cin   = 1'b0;
    @(negedge clk);
    bus.start = 1'b0;
    tests_run++; if (bus.busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_busy_t2: got %b expected 1", bus.busy); end
    @(negedge clk);
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_done_t3: got %b expected 0", bus.done); end
    @(negedge clk);
    tests_run++; if (bus.done !== 1'b1) begin tests_failed++; $display("[TB] FAIL ign_done_t4: got %b expected 1", bus.done); end
    tests_run++; if (bus.sum !== 16'h5556) begin tests_failed++; $display("[TB] FAIL ign_sum: got %h expected 5556", bus.sum); end
    tests_run++; if (bus.cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_cout: got %b expected 0", bus.cout); end
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_busy_t5: got %b expected 0", bus.busy); end
    @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ign_busy_t6: got %b expected 0", bus.busy); end
  endtask

  task automatic test_add_vectors();
    logic [15:0] va [3] = '{16'hFFFF, 16'hA5A5, 16'h0F0F};
    logic [15:0] vb [3] = '{16'h0001, 16'h5A5A, 16'h00F1};
    logic        vc [3] = '{1'b0, 1'b1, 1'b0};
    logic [15:0] es [3] = '{16'h0000, 16'h0000, 16'h1000};
    logic        ec [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] prev_sum  = 16'h5556;
    logic        prev_cout = 1'b0;
    int cycles;
    bit seen;
    for (int i = 0; i < 3; i++) begin
      accept_op(va[i], vb[i], vc[i], 1'b0);
      tests_run++; if (bus.sum !== prev_sum) begin tests_failed++; $display("[TB] FAIL add%0d_hold_sum: got %h expected %h", i, bus.sum, prev_sum); end
      tests_run++; if (bus.cout !== prev_cout) begin tests_failed++; $display("[TB] FAIL add%0d_hold_cout: got %b expected %b", i, bus.cout, prev_cout); end
      wait_done(cycles, seen);
      tests_run++; if (!seen || cycles != NIBBLES) begin tests_failed++; $display("[TB] FAIL add%0d_latency: got seen=%0d cycles=%0d expected seen=1 cycles=%0d", i, seen, cycles, NIBBLES); end
      tests_run++; if (bus.sum !== es[i]) begin tests_failed++; $display("[TB] FAIL add%0d_sum: got %h expected %h", i, bus.sum, es[i]); end
      tests_run++; if (bus.cout !== ec[i]) begin tests_failed++; $display("[TB] FAIL add%0d_cout: got %b expected %b", i, bus.cout, ec[i]); end
      prev_sum  = es[i];
      prev_cout = ec[i];
    end
  endtask

  task automatic test_reset_abort();
    int cycles;
    bit seen;
    accept_op(16'h8000, 16'h8000, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.sum !== 16'h0000) begin tests_failed++; $display("[TB] FAIL abort_sum: got %h expected 0000", bus.sum); end
    tests_run++; if (bus.cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL abort_cout: got %b expected 0", bus.cout); end
    @(negedge clk);
    rst = 1'b0;
    wait_done(cycles, seen);
    tests_run++; if (seen) begin tests_failed++; $display("[TB] FAIL abort_no_done: got done after %0d cycles expected none", cycles); end
    accept_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
    wait_done(cycles, seen);
    tests_run++; if (!seen || cycles != NIBBLES) begin tests_failed++; $display("[TB] FAIL post_abort_latency: got seen=%0d cycles=%0d expected seen=1 cycles=%0d", seen, cycles, NIBBLES); end
    tests_run++; if (bus.sum !== 16'h0100) begin tests_failed++; $display("[TB] FAIL post_abort_sum: got %h expected 0100", bus.sum); end
    tests_run++; if (bus.cout !== 1'b0) begin tests_failed++; $display("[TB] FAIL post_abort_cout: got %b expected 0", bus.cout); end
  endtask

  task automatic test_subtract();
    logic [15:0] va [2] = '{16'h0005, 16'h0007};
    logic [15:0] vb [2] = '{16'h0007, 16'h0005};
`ifdef RCA_SEQ_CTRL_SUB_EN
    logic [15:0] es [2] = '{16'hFFFE, 16'h0002};
    logic        ec [2] = '{1'b0, 1'b1};
`else
    logic [15:0] es [2] = '{16'h000C, 16'h000C};
    logic        ec [2] = '{1'b0, 1'b0};
`endif
    int cycles;
    bit seen;
    for (int i = 0; i < 2; i++) begin
      accept_op(va[i], vb[i], 1'b0, 1'b1);
      wait_done(cycles, seen);
      tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL sub%0d_done: got no done in %0d cycles expected done", i, cycles); end
      tests_run++; if (bus.sum !== es[i]) begin tests_failed++; $display("[TB] FAIL sub%0d_sum: got %h expected %h", i, bus.sum, es[i]); end
      tests_run++; if (bus.cout !== ec[i]) begin tests_failed++; $display("[TB] FAIL sub%0d_cout: got %b expected %b", i, bus.cout, ec[i]); end
    end
  endtask

  task automatic test_back_to_back();
    int cycles;
    bit seen;
    @(negedge clk);
    bus.a     = 16'h0001;
    bus.b     = 16'h0002;
    bus.cin   = 1'b0;
    bus.op    = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    wait_done(cycles, seen);
    tests_run++; if (!seen || cycles != NIBBLES) begin tests_failed++; $display("[TB] FAIL b2b_first_latency: got seen=%0d cycles=%0d expected seen=1 cycles=%0d", seen, cycles, NIBBLES); end
    tests_run++; if (bus.sum !== 16'h0003) begin tests_failed++; $display("[TB] FAIL b2b_first_sum: got %h expected 0003", bus.sum); end
    bus.a = 16'h0010;
    bus.b = 16'h0020;
    wait_done(cycles, seen);
    bus.start = 1'b0;
    tests_run++; if (!seen || cycles != NIBBLES + 2) begin tests_failed++; $display("[TB] FAIL b2b_second_latency: got seen=%0d cycles=%0d expected seen=1 cycles=%0d", seen, cycles, NIBBLES + 2); end
    tests_run++; if (bus.sum !== 16'h0030) begin tests_failed++; $display("[TB] FAIL b2b_second_sum: got %h expected 0030", bus.sum); end
    repeat (2) @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL b2b_idle: got %b expected 0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_ignore_start();
    test_add_vectors();
    test_reset_abort();
    test_subtract();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule

// File: doc/rca_seq_ctrl.md
RCA_SEQ_CTRL -- requirements
Module: rca_seq_ctrl

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices per operand; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1, request to begin an operation; sampled only in IDLE.
REQ-005 The block SHALL have port a, input, W, operand A.
REQ-006 The block SHALL have port b, input, W, operand B.
REQ-007 The block SHALL have port cin, input, 1, carry-in for addition.
REQ-008 The block SHALL have port op, input, 1, operation select: 0 = add, 1 = subtract.
REQ-009 The block SHALL have port busy, output, 1, high while an operation is in progress (RUN or DONE).
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse marking a valid new result.
REQ-011 The block SHALL have port sum, output, W, result register.
REQ-012 The block SHALL have port cout, output, 1, final carry-out of the most significant slice.

Function
REQ-013 The block SHALL contain exactly one 4-bit ripple-carry adder slice, built from full-adder cells, that is reused once per nibble.
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; the reset state is IDLE.
REQ-015 In IDLE with start=1 at an edge, the block SHALL latch a, b, cin and op, clear the nibble index to 0, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE.
REQ-017 In RUN, each edge SHALL process nibble[index], LSB nibble first.
- Slice carry-in is the carry register: latched cin for nibble 0, the previous slice carry-out thereafter.
- The 4-bit slice result is stored into a working register; the index is incremented.
REQ-018 On the edge that processes nibble NIBBLES-1, the block SHALL load sum from the working register, load cout from the slice carry-out, and enter DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-020 Latency SHALL be fixed.
- With start accepted at edge T0, done is high in the cycle following edge T(NIBBLES).
- The block is back in IDLE after edge T(NIBBLES+1).
REQ-021 busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-022 sum and cout SHALL hold the previous result during RUN and until the next completion.
REQ-023 start SHALL be ignored in RUN and DONE; changes on a, b, cin and op after the accepting edge SHALL NOT affect the result.
REQ-024 Arithmetic SHALL be modulo 2^W; the carry out of bit W-1 SHALL appear on cout only, with no overflow flag.

Reset
REQ-025 While rst=1, independent of clk, the block SHALL force state=IDLE, index=0, carry=0, busy=0, done=0, sum=0 and cout=0.
REQ-026 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse; after release, the next accepted start SHALL behave normally.

Configuration
REQ-027 Macro RCA_SEQ_CTRL_SUB_EN SHALL control subtraction.
- Defined, with op latched as 1: each B nibble is inverted before the slice, the nibble-0 carry-in is forced to 1 (cin ignored), and the result is a-b mod 2^W, with cout=1 meaning no borrow.
- Not defined: op is accepted but ignored, and every operation is a+b+cin.

Verification (NIBBLES=4)
REQ-028 a=0x0000, b=0x0000, cin=0, start at T0 -> busy high from T0; done pulse after T4; sum=0x0000, cout=0; idle after T5.
REQ-029 a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1, proving the carry propagates across all four nibble passes.
REQ-030 a=0x1234, b=0x4321, cin=1 -> sum=0x5556, cout=0; a second start pulse at T2 is ignored and the done timing is unchanged.
REQ-031 a=0x8000, b=0x8000 started, then rst pulsed after T2 -> busy=0, sum=0, cout=0 immediately, and no done pulse; then a=0x00FF, b=0x0001 -> sum=0x0100.
REQ-032 With RCA_SEQ_CTRL_SUB_EN defined: op=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0; op=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1. Without the macro, the same stimulus -> sum=0x000C, cout=0.
